// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, round constants, initial hash values and the
// message-schedule sigma functions.
package sha256_pkg;

  typedef logic [31:0] word_t;
  typedef logic [5:0]  round_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sched_state_t;

  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam word_t IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic word_t rotr(input word_t x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t s0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t s1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Registered 64x32 SHA-256 round-constant ROM; data updates only when en is high.
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   en,
  input  round_t addr,
  output word_t  data
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data <= '0;
    end else if (en) begin
      data <= K[addr];
    end
  end

endmodule

// File: rtl/sha256_msg_scheduler.sv
// SHA-256 message scheduler: expands one 512-bit block into W[0..63] over a
// 16-word circular buffer. Optional K[t] output under SHA256_SCHED_K_ROM_EN.
module sha256_msg_scheduler
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [511:0] block_in,
  output logic         busy,
  output logic         w_valid,
  input  logic         w_ready,
  output word_t        w_out,
  output round_t       round_out,
  output logic         done,
  output sched_state_t dbg_state
`ifdef SHA256_SCHED_K_ROM_EN
  ,
  output word_t        k_out
`endif
);

  // Handshake: a word transfers on any rising edge where w_valid and w_ready
  // are both high; w_out/round_out (and k_out) stay frozen until then.

  localparam round_t LAST = round_t'(ROUNDS - 1);

  sched_state_t state;
  word_t        word_buf [16];
  word_t        w_next;
  round_t       next_round;
  logic [3:0]   slot_n, slot_m2, slot_m7, slot_m15;
  logic         transfer, last;

  assign transfer   = w_valid & w_ready;
  assign last       = (round_out == LAST);
  assign next_round = round_out + 6'd1;
  assign dbg_state  = state;

  // Slot t mod 16 still holds W[t-16] until it is overwritten with W[t].
  assign slot_n   = next_round[3:0];
  assign slot_m2  = slot_n - 4'd2;
  assign slot_m7  = slot_n - 4'd7;
  assign slot_m15 = slot_n + 4'd1;

  always_comb begin
    w_next = word_buf[slot_n];
    if (next_round[5:4] != 2'b00) begin
      w_next = s1(word_buf[slot_m2]) + word_buf[slot_m7]
             + s0(word_buf[slot_m15]) + word_buf[slot_n];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      w_valid   <= 1'b0;
      w_out     <= '0;
      round_out <= '0;
      done      <= 1'b0;
      for (int i = 0; i < 16; i++) word_buf[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            for (int i = 0; i < 16; i++) word_buf[i] <= block_in[511-32*i -: 32];
            w_out     <= block_in[511:480];
            round_out <= '0;
            w_valid   <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (transfer) begin
            if (last) begin
              w_valid <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              w_out     <= w_next;
              round_out <= next_round;
              if (next_round[5:4] != 2'b00) word_buf[slot_n] <= w_next;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SHA256_SCHED_K_ROM_EN
  logic   rom_en;
  round_t rom_addr;

  // ROM is addressed with the round being loaded so its registered output
  // lines up with w_out on the same edge.
  assign rom_en   = ((state == ST_IDLE) & start) | ((state == ST_RUN) & transfer & ~last);
  assign rom_addr = (state == ST_IDLE) ? 6'd0 : next_round;

  sha256_k_rom u_k_rom (
    .clk   (clk),
    .reset (reset),
    .en    (rom_en),
    .addr  (rom_addr),
    .data  (k_out)
  );
`endif

endmodule
